tnn_feature_framer: RTL
=======================

Name: tnn_feature_framer

Overview:
- Upstream front-end for the 8-input, 2-bit-per-feature approximate TNN classifier cores, e.g. breastcancer 2-bit, 8 features, 1-bit class.
- Accepts a serial stream of 2-bit quantised features over valid/ready and assembles them into one frame.
- Holds the frame stable on the classifier's feature inputs for a settle window, then samples the 1-bit class.
- Emits the class as a one-entry valid/ready result.

Parameters:
- FEAT_W, 2, bits per feature; must match the classifier core.
- NUM_FEAT, 8, features per frame; must be 8 for the current core family.
- SETTLE_CYCLES, 1, cycles the frame is held before the class is sampled; legal range 1..15.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- s_valid  in  1  feature beat valid.
- s_ready  out  1  framer can accept a beat.
- s_data  in  FEAT_W  feature value; first beat is feature a, last beat is feature h.
- s_last  in  1  marks the final beat of a frame.
- feat_a .. feat_h  out  FEAT_W each  registered feature vector driven to the classifier inputs.
- cls_in  in  1  classifier output (cgp_out[0]).
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- m_class  out  1  captured class.
- frame_err  out  1  one-cycle pulse when a frame is dropped for a framing error.
- cnt_frames  out  16  frames classified (PERF_COUNT_EN only).
- cnt_pos  out  16  frames with class 1 (PERF_COUNT_EN only).

Behaviour:
- Reset: while rst_n=0 at a rising edge, the following are cleared:
  - state goes to COLLECT, beat index to 0;
  - feat_a..h = 0, m_valid = 0, m_class = 0, frame_err = 0;
  - both counters = 0.
  - Reset mid-frame or mid-result discards everything; there is no partial carry-over.
- Beat acceptance: a beat is accepted when s_valid && s_ready. s_ready = 1 only in COLLECT.
- COLLECT:
  - Each accepted beat writes s_data into feature[idx], then idx increments.
  - Beat at idx=7 with s_last=1: go to SETTLE with settle count = 0, idx = 0.
  - Beat at idx=7 with s_last=0, or s_last=1 at idx<7: framing error.
    - frame_err pulses for 1 cycle, idx = 0, stay in COLLECT.
    - Feature registers keep their partially written contents; the frame is not classified.
- SETTLE:
  - feat_* are stable and s_ready = 0.
  - The counter increments each cycle.
  - When it reaches SETTLE_CYCLES-1, register m_class = cls_in, set m_valid = 1, and go to RESULT.
  - With SETTLE_CYCLES=1, cls_in is sampled on the first cycle after the final beat.
- RESULT:
  - m_valid = 1 and m_class is held until m_valid && m_ready.
  - On that handshake: m_valid = 0, go to COLLECT; s_ready rises the following cycle.
  - feat_* stay unchanged until the next frame's beats overwrite them.
- Latency: last beat accepted at cycle T gives m_valid at cycle T+SETTLE_CYCLES+1. Minimum frame period with m_ready tied high is 8 + SETTLE_CYCLES + 1 cycles.
- s_data is ignored when s_valid=0. cls_in is never sampled outside the SETTLE exit cycle.
- Backpressure: no beat is accepted in SETTLE or RESULT, so a stalled consumer stalls the feature stream without loss.

Optional Feature:
- Macro: TNN_FRAMER_PERF_COUNT_EN.
- Defined:
  - cnt_frames increments on each result handshake.
  - cnt_pos increments on each result handshake where m_class=1.
  - Both are 16-bit and wrap from 0xFFFF to 0x0000.
  - Both clear on reset.
- Undefined: cnt_frames and cnt_pos are tied to 0 and no counter flops are inferred.

Test Plan:
- Reset, then stream 3,1,0,2,3,3,0,1 with s_last on the 8th beat and m_ready=1 -> feat_a..h = 3,1,0,2,3,3,0,1; m_valid pulses at T+2 with m_class equal to cls_in sampled then (model with a stub classifier, e.g. cls=feat_a[1]&feat_e[1] -> 1).
- Same frame with m_ready=0 for 5 cycles -> m_valid and m_class held; s_ready=0 and s_valid beats are not consumed; on release s_ready=1 the cycle after the handshake.
- s_last on the 5th beat -> frame_err one-cycle pulse, no m_valid; the next 8-beat frame classifies normally.
- 8 beats with no s_last -> frame_err on the 8th beat, idx returns to 0.
- rst_n=0 during SETTLE with SETTLE_CYCLES=4 -> m_valid never asserts, all outputs 0, and the next frame completes with latency 5.
- With TNN_FRAMER_PERF_COUNT_EN, preload to 0xFFFF via 65535 frames (or force), then one class-1 frame -> both counters read 0x0000; without the macro, both read 0 throughout.

Source files
------------

// File: rtl/tnn_feature_framer.sv
// Serial 2-bit feature framer for the 8-input TNN classifier: collects a frame, settles it, captures the class.
// Optional performance counters are enabled by defining TNN_FRAMER_PERF_COUNT_EN.
module tnn_feature_framer #(
   parameter int FEAT_W        = 2,
   parameter int NUM_FEAT      = 8,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [FEAT_W-1:0] s_data,
   input  logic              s_last,
   output logic [FEAT_W-1:0] feat_a,
   output logic [FEAT_W-1:0] feat_b,
   output logic [FEAT_W-1:0] feat_c,
   output logic [FEAT_W-1:0] feat_d,
   output logic [FEAT_W-1:0] feat_e,
   output logic [FEAT_W-1:0] feat_f,
   output logic [FEAT_W-1:0] feat_g,
   output logic [FEAT_W-1:0] feat_h,
   input  logic              cls_in,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_class,
   output logic              frame_err,
   output logic [15:0]       cnt_frames,
   output logic [15:0]       cnt_pos
);

   localparam int               IDX_W       = $clog2(NUM_FEAT);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_FEAT - 1);
   localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      SETTLE  = 2'd1,
      RESULT  = 2'd2
   } state_t;

   state_t            state_r;
   logic [IDX_W-1:0]  idx_r;
   logic [3:0]        settle_cnt_r;
   logic [FEAT_W-1:0] feat_r [NUM_FEAT];
   logic              m_valid_r;
   logic              m_class_r;
   logic              frame_err_r;
   logic              beat_s;
   logic              res_hs_s;

   assign beat_s   = s_valid && (state_r == COLLECT);
   assign res_hs_s = m_valid_r && m_ready;

   // Frame collection, settle timing and result capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= COLLECT;
         idx_r        <= {IDX_W{1'b0}};
         settle_cnt_r <= 4'd0;
         m_valid_r    <= 1'b0;
         m_class_r    <= 1'b0;
         frame_err_r  <= 1'b0;
         for (int i = 0; i < NUM_FEAT; i++) begin
            feat_r[i] <= {FEAT_W{1'b0}};
         end
      end else begin
         frame_err_r <= 1'b0;
         case (state_r)
            COLLECT: begin
               if (beat_s) begin
                  feat_r[idx_r] <= s_data;
                  if ((idx_r == LAST_IDX) && s_last) begin
                     state_r      <= SETTLE;
                     settle_cnt_r <= 4'd0;
                     idx_r        <= {IDX_W{1'b0}};
                  end else if ((idx_r == LAST_IDX) || s_last) begin
                     // Misframed beat: drop the frame, keep partial features
                     frame_err_r <= 1'b1;
                     idx_r       <= {IDX_W{1'b0}};
                  end else begin
                     idx_r <= idx_r + IDX_ONE;
                  end
               end
            end
            SETTLE: begin
               if (settle_cnt_r == SETTLE_LAST) begin
                  m_class_r <= cls_in;
                  m_valid_r <= 1'b1;
                  state_r   <= RESULT;
               end else begin
                  settle_cnt_r <= settle_cnt_r + 4'd1;
               end
            end
            RESULT: begin
               if (res_hs_s) begin
                  m_valid_r <= 1'b0;
                  state_r   <= COLLECT;
               end
            end
            default: begin
               state_r   <= COLLECT;
               idx_r     <= {IDX_W{1'b0}};
               m_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign s_ready   = (state_r == COLLECT);
   assign m_valid   = m_valid_r;
   assign m_class   = m_class_r;
   assign frame_err = frame_err_r;
   assign feat_a    = feat_r[0];
   assign feat_b    = feat_r[1];
   assign feat_c    = feat_r[2];
   assign feat_d    = feat_r[3];
   assign feat_e    = feat_r[4];
   assign feat_f    = feat_r[5];
   assign feat_g    = feat_r[6];
   assign feat_h    = feat_r[7];

`ifdef TNN_FRAMER_PERF_COUNT_EN
   logic [15:0] cnt_frames_r;
   logic [15:0] cnt_pos_r;

   // Wrapping counters of delivered results and positive classes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_frames_r <= 16'd0;
         cnt_pos_r    <= 16'd0;
      end else if (res_hs_s) begin
         cnt_frames_r <= cnt_frames_r + 16'd1;
         if (m_class_r) begin
            cnt_pos_r <= cnt_pos_r + 16'd1;
         end
      end
   end

   assign cnt_frames = cnt_frames_r;
   assign cnt_pos    = cnt_pos_r;
`else
   assign cnt_frames = 16'd0;
   assign cnt_pos    = 16'd0;
`endif

endmodule
